// File: rtl/pool3_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pool3_scheduler
// Description : Sequences the pooling datapath over NUM_CH channels. Each
//               channel gets a one-cycle setup, a watchdog-guarded compute
//               window (cal_en) and a minimum idle gap. A one-cycle
//               layer_done pulse follows the last channel.
// Revision    : 1.0 - initial release
// ============================================================================
module pool3_scheduler #(
  parameter int NUM_CH    = 16,
  parameter int CH_STRIDE = 25,
  parameter int GAP       = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        pool_done,
  output logic        cal_en,
  output logic [11:0] base_position,
  output logic [4:0]  ch_idx,
  output logic        busy,
  output logic        layer_done,
  output logic        timeout_err
);

  localparam logic [4:0]  LAST_CH  = 5'(NUM_CH - 1);
  localparam logic [11:0] STRIDE   = 12'(CH_STRIDE);
  localparam logic [11:0] WD_LIMIT = 12'(TIMEOUT);
  localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ch_idx_q, ch_idx_d;
  logic [11:0] base_q, base_d;
  logic [11:0] wd_q, wd_d;
  logic [3:0]  gap_q, gap_d;
  logic        terr_q, terr_d;
  logic        cal_en_q, cal_en_d;
  logic        busy_q, busy_d;
  logic        layer_done_q, layer_done_d;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    base_d   = base_q;
    wd_d     = wd_q;
    gap_d    = gap_q;
    terr_d   = terr_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_SETUP;
          ch_idx_d = 5'd0;
          base_d   = 12'd0;
          terr_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        // Watchdog starts from zero on the first RUN cycle
        state_d = ST_RUN;
        wd_d    = 12'd0;
      end
      ST_RUN: begin
        wd_d = wd_q + 12'd1;
        if (pool_done) begin
          // Completion beats a simultaneous watchdog expiry
          state_d = ST_GAP;
          gap_d   = 4'd0;
        end else if (wd_q == WD_LIMIT) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end
      end
      ST_GAP: begin
        // Wait out the minimum gap and for the datapath to drop pool_done,
        // so a lingering completion is never credited to the next channel
        if ((gap_q >= GAP_LAST) && !pool_done) begin
          if (ch_idx_q == LAST_CH) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SETUP;
            ch_idx_d = ch_idx_q + 5'd1;
            base_d   = base_q + STRIDE;
          end
        end else if (gap_q != 4'hF) begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE; channel position and error
    // flag are left as they were
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      ch_idx_d = ch_idx_q;
      base_d   = base_q;
      terr_d   = terr_q;
    end

    cal_en_d     = (state_d == ST_RUN);
    busy_d       = (state_d != ST_IDLE);
    layer_done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_idx_q     <= 5'd0;
      base_q       <= 12'd0;
      wd_q         <= 12'd0;
      gap_q        <= 4'd0;
      terr_q       <= 1'b0;
      cal_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_idx_q     <= ch_idx_d;
      base_q       <= base_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
      terr_q       <= terr_d;
      cal_en_q     <= cal_en_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign cal_en        = cal_en_q;
  assign base_position = base_q;
  assign ch_idx        = ch_idx_q;
  assign busy          = busy_q;
  assign layer_done    = layer_done_q;
  assign timeout_err   = terr_q;

endmodule
`default_nettype wire
